// File: rtl/hazard_scoreboard.sv
// Hazard unit for the 5-stage MIPS core: forwarding selects, load-use/branch stalls, one-deep mul-div scoreboard.
// Optional W->M store-data forwarding is enabled by defining HAZARD_MEM_FWD_EN.
module hazard_scoreboard #(
    parameter int AW    = 5,
    parameter int MDLAT = 4,
    parameter int CW    = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] rsD,
    input  logic [AW-1:0] rtD,
    input  logic [AW-1:0] writeregD,
    input  logic          regwriteD,
    input  logic          branchD,
    input  logic          memwriteD,
    input  logic          mdD,
    input  logic [AW-1:0] rsE,
    input  logic [AW-1:0] rtE,
    input  logic [AW-1:0] writeregE,
    input  logic          regwriteE,
    input  logic          memtoregE,
    input  logic          mdstartE,
    input  logic [AW-1:0] mdregE,
    input  logic [AW-1:0] rtM,
    input  logic [AW-1:0] writeregM,
    input  logic          regwriteM,
    input  logic          memtoregM,
    input  logic          memwriteM,
    input  logic [AW-1:0] writeregW,
    input  logic          regwriteW,
    output logic          forwardaD,
    output logic          forwardbD,
    output logic [1:0]    forwardaE,
    output logic [1:0]    forwardbE,
    output logic          forwardM,
    output logic          stallF,
    output logic          stallD,
    output logic          flushE,
    output logic          mdbusy,
    output logic          mdwriteW,
    output logic [AW-1:0] mdregW,
    output logic [CW-1:0] stallcount
);
    localparam int CNTW = $clog2(MDLAT) + 1;

    logic            r_busy;
    logic [CNTW-1:0] r_cnt;
    logic [AW-1:0]   r_mdreg;
    logic [CW-1:0]   r_stallcount;

    logic w_lwraw, w_lwstall, w_branchstall, w_mdstall, w_stall;
    logic w_mdwrite, w_pending, w_hit_busy, w_hit_issue, w_accept;

    assign forwardaD = (rsD != '0) & (rsD == writeregM) & regwriteM;
    assign forwardbD = (rtD != '0) & (rtD == writeregM) & regwriteM;

    always_comb begin
        forwardaE = 2'b00;
        if (rsE != '0 && rsE == writeregM && regwriteM)      forwardaE = 2'b10;
        else if (rsE != '0 && rsE == writeregW && regwriteW) forwardaE = 2'b01;
        forwardbE = 2'b00;
        if (rtE != '0 && rtE == writeregM && regwriteM)      forwardbE = 2'b10;
        else if (rtE != '0 && rtE == writeregW && regwriteW) forwardbE = 2'b01;
    end

    assign w_lwraw = memtoregE & ((rtE == rsD) | (rtE == rtD));

`ifdef HAZARD_MEM_FWD_EN
    // A store whose only dependency is its data operand picks the load value up via W->M.
    assign w_lwstall = w_lwraw & ~(memwriteD & (rtE == rtD) & (rtE != rsD));
    assign forwardM  = memwriteM & (rtM != '0) & (rtM == writeregW) & regwriteW;
`else
    assign w_lwstall = w_lwraw;
    assign forwardM  = 1'b0;
`endif

    assign w_branchstall = branchD &
        ((regwriteE & ((writeregE == rsD) | (writeregE == rtD))) |
         (memtoregM & ((writeregM == rsD) | (writeregM == rtD))));

    assign w_mdwrite   = r_busy & (r_cnt == '0);
    assign w_pending   = r_busy & ~w_mdwrite;
    assign w_hit_busy  = ((r_mdreg != '0) & ((r_mdreg == rsD) | (r_mdreg == rtD))) |
                         (regwriteD & (writeregD == r_mdreg)) | mdD;
    assign w_hit_issue = ((mdregE != '0) & ((mdregE == rsD) | (mdregE == rtD))) |
                         (regwriteD & (writeregD == mdregE)) | mdD;
    assign w_mdstall   = (w_pending & w_hit_busy) | (mdstartE & w_hit_issue);

    assign w_stall = w_lwstall | w_branchstall | w_mdstall;
    assign stallD  = w_stall;
    assign stallF  = w_stall;
    assign flushE  = w_stall;

    // The op in E only bubbles decode through its own dependency; that bubble must not cancel the op itself.
    assign w_accept = mdstartE & (~r_busy | w_mdwrite) & ~(w_lwstall | w_branchstall);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_mdreg <= '0;
        end else if (w_accept) begin
            r_busy  <= 1'b1;
            r_cnt   <= CNTW'(MDLAT - 1);
            r_mdreg <= mdregE;
        end else if (r_busy) begin
            if (r_cnt != '0) r_cnt  <= r_cnt - 1'b1;
            else             r_busy <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                               r_stallcount <= '0;
        else if (w_stall && r_stallcount != '1)  r_stallcount <= r_stallcount + 1'b1;
    end

    assign mdbusy     = r_busy;
    assign mdwriteW   = w_mdwrite;
    assign mdregW     = r_mdreg;
    assign stallcount = r_stallcount;
endmodule
